// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter/sequencer in front of a single-ported
// word memory. Port 0 is the instruction-fetch side and port 1 is the load/store unit.
// Each granted access runs IDLE -> ACCESS -> RESP, which allows at most one
// access every three cycles.
//
// Handshake: a requester raises reqN with weN/addrN/wdataN stable and holds them
// until it sees the one-cycle ackN pulse. By the edge after the ack it either drops
// reqN or presents the next request. reqN is ignored while the arbiter is busy.
module dmem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              gnt_id,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_gnt;
    logic                r_last;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic                w_any_req;
    logic                w_winner;
    logic                w_mem_read;
    logic                w_mem_write;
    logic                w_ack0;
    logic                w_ack1;

    // Arbitration: a single requester always wins. A tie goes to the port not
    // granted last time (round-robin), or to port 1 under fixed priority.
    always_comb begin
        w_any_req = req0 | req1;
        w_winner  = 1'b0;
        if (req0 && req1) begin
            w_winner = RR_EN ? ~r_last : 1'b1;
        end else if (req1) begin
            w_winner = 1'b1;
        end
    end

    // Next-state and decoded outputs. The memory strobes exist only in ACCESS.
    // rst gates mem_write combinationally, so a reset landing on a write
    // cycle cannot corrupt memory.
    always_comb begin
        w_next_state = r_state;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_ack0       = 1'b0;
        w_ack1       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                w_mem_read   = ~r_we;
                w_mem_write  = r_we & ~rst;
                w_next_state = ST_RESP;
            end
            ST_RESP: begin
                w_ack0       = ~r_gnt;
                w_ack1       = r_gnt;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture the winner's command at grant time. These registers also serve as
    // the memory address/data outputs, so they hold their value outside ACCESS.
    // r_last resets to 1 so that port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
        end else if (r_state == ST_IDLE && w_any_req) begin
            r_we    <= w_winner ? we1 : we0;
            r_addr  <= w_winner ? addr1 : addr0;
            r_wdata <= w_winner ? wdata1 : wdata0;
            r_gnt   <= w_winner;
            r_last  <= w_winner;
        end
    end

    // Capture read data at the closing edge of ACCESS. Only the granted port's
    // result register is updated, and only on reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else if (r_state == ST_ACCESS && !r_we) begin
            if (r_gnt) begin
                r_rdata1 <= mem_rdata;
            end else begin
                r_rdata0 <= mem_rdata;
            end
        end
    end

    assign ack0      = w_ack0;
    assign ack1      = w_ack1;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_read  = w_mem_read;
    assign mem_write = w_mem_write;
    assign busy      = (r_state != ST_IDLE);
    assign gnt_id    = r_gnt;
    assign dbg_state = r_state;

endmodule
